car_sequencer: RTL and testbench

CAR_SEQUENCER -- requirements
Module: car_sequencer

---
 rtl/car_sequencer_pkg.sv | 61 ++++++
 rtl/car_sequencer_if.sv | 27 ++
 rtl/seq_decode.sv | 96 +++++++++
 rtl/car_sequencer.sv | 56 +++++
 tb/tb_car_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/car_sequencer_pkg.sv
`default_nettype none
// car_sequencer_pkg -- CAR encodings, ISA field constants and helpers shared with the control unit.
// Rev 1.0

package car_sequencer_pkg;

  localparam int C_CAR_BITS = 6;

  typedef enum logic [5:0] {
    CAR_RESET      = 6'd0,
    CAR_RST_VEC    = 6'd1,
    CAR_FETCH      = 6'd2,
    CAR_DECODE     = 6'd3,
    CAR_SRC_IDX    = 6'd4,
    CAR_SRC_RD     = 6'd5,
    CAR_SRC_RDINC  = 6'd6,
    CAR_DST_IDX    = 6'd7,
    CAR_DST_RD     = 6'd8,
    CAR_EXEC       = 6'd9,
    CAR_DST_WR     = 6'd10,
    CAR_PUSH_DEC   = 6'd11,
    CAR_PUSH_WR    = 6'd12,
    CAR_CALL_PC    = 6'd13,
    CAR_POP_SR     = 6'd14,
    CAR_POP_PC     = 6'd15,
    CAR_JMP_EXEC   = 6'd16,
    CAR_INT_PUSHPC = 6'd17,
    CAR_INT_PUSHSR = 6'd18,
    CAR_INT_VEC    = 6'd19
  } car_t;

  localparam logic [3:0] C_OP_FMT1_MIN = 4'h4;
  localparam logic [3:0] C_OP_MOV      = 4'h4;
  localparam logic [3:0] C_OP_CMP      = 4'h9;
  localparam logic [3:0] C_OP_BIT      = 4'hB;

  localparam logic [5:0] C_FMT2_PREFIX = 6'b000100;
  localparam logic [8:0] C_RETI_PREFIX = 9'b000100110;
  localparam logic [2:0] C_JMP_PREFIX  = 3'b001;

  localparam logic [2:0] C_F2_RRC  = 3'd0;
  localparam logic [2:0] C_F2_SWPB = 3'd1;
  localparam logic [2:0] C_F2_RRA  = 3'd2;
  localparam logic [2:0] C_F2_SXT  = 3'd3;
  localparam logic [2:0] C_F2_PUSH = 3'd4;
  localparam logic [2:0] C_F2_CALL = 3'd5;

  localparam logic [1:0] C_AS_REG = 2'd0;
  localparam logic [1:0] C_AS_IDX = 2'd1;
  localparam logic [1:0] C_AS_IND = 2'd2;
  localparam logic [1:0] C_AS_INC = 2'd3;

  function automatic logic is_mem_state(input car_t s);
    return s inside {CAR_RST_VEC, CAR_FETCH, CAR_SRC_IDX, CAR_SRC_RD, CAR_SRC_RDINC,
                     CAR_DST_IDX, CAR_DST_RD, CAR_DST_WR, CAR_PUSH_WR, CAR_POP_SR,
                     CAR_POP_PC, CAR_INT_PUSHPC, CAR_INT_PUSHSR, CAR_INT_VEC};
  endfunction

endpackage

`default_nettype wire

// File: rtl/car_sequencer_if.sv
`default_nettype none
// car_sequencer_if -- instruction/memory/interrupt inputs and control-address outputs of the sequencer.
// Rev 1.0

interface car_sequencer_if #(
  parameter int CAR_BITS = car_sequencer_pkg::C_CAR_BITS
);
  logic [15:0]         IR;
  logic                MemReady;
  logic                IRQ;
  logic                GIE;
  logic [CAR_BITS-1:0] CAR;
  logic                IRload;
  logic                InstrDone;

  modport master (
    input  IR, MemReady, IRQ, GIE,
    output CAR, IRload, InstrDone
  );

  modport slave (
    output IR, MemReady, IRQ, GIE,
    input  CAR, IRload, InstrDone
  );
endinterface

`default_nettype wire

// File: rtl/seq_decode.sv
`default_nettype none
// seq_decode -- maps (IR, current phase) to the next phase assuming memory is ready and no interrupt.
// Rev 1.0

module seq_decode
  import car_sequencer_pkg::*;
(
  input  logic [15:0] i_ir,
  input  car_t        i_phase,
  output car_t        o_next
);

  logic       w_fmt1;
  logic       w_fmt2;
  logic       w_jump;
  logic       w_reti;
  logic       w_ad;
  logic       w_const_gen;
  logic       w_unused;
  logic [1:0] w_as;
  logic [2:0] w_op2;
  logic [3:0] w_opc;
  logic [3:0] w_src_reg;
  car_t       w_after_src;
  car_t       w_src_entry;
  car_t       w_after_exec;

  assign w_opc       = i_ir[15:12];
  assign w_op2       = i_ir[9:7];
  assign w_as        = i_ir[5:4];
  assign w_ad        = i_ir[7];
  assign w_jump      = (i_ir[15:13] == C_JMP_PREFIX);
  assign w_fmt1      = (w_opc >= C_OP_FMT1_MIN);
  assign w_fmt2      = (i_ir[15:10] == C_FMT2_PREFIX) && (w_op2 <= C_F2_CALL);
  assign w_reti      = (i_ir[15:7] == C_RETI_PREFIX);
  // Format II carries its single operand in the destination field.
  assign w_src_reg   = w_fmt1 ? i_ir[11:8] : i_ir[3:0];
  assign w_const_gen = (w_src_reg == 4'd3) || ((w_src_reg == 4'd2) && w_as[1]);
  assign w_unused    = i_ir[6];

  always_comb begin
    w_after_src  = (w_fmt1 && w_ad) ? CAR_DST_IDX : CAR_EXEC;
    w_src_entry  = w_after_src;
    if (!w_const_gen) begin
      case (w_as)
        C_AS_IDX: w_src_entry = CAR_SRC_IDX;
        C_AS_IND: w_src_entry = CAR_SRC_RD;
        C_AS_INC: w_src_entry = CAR_SRC_RDINC;
        default:  w_src_entry = w_after_src;
      endcase
    end

    w_after_exec = CAR_FETCH;
    if (w_fmt2 && ((w_op2 == C_F2_PUSH) || (w_op2 == C_F2_CALL)))
      w_after_exec = CAR_PUSH_DEC;
    else if (w_fmt1 && w_ad && (w_opc != C_OP_CMP) && (w_opc != C_OP_BIT))
      w_after_exec = CAR_DST_WR;
    else if (w_fmt2 && (w_op2 <= C_F2_SXT) && (w_as != C_AS_REG))
      w_after_exec = CAR_DST_WR;
  end

  always_comb begin
    o_next = CAR_RESET;
    case (i_phase)
      CAR_RESET:      o_next = CAR_RST_VEC;
      CAR_RST_VEC:    o_next = CAR_FETCH;
      CAR_FETCH:      o_next = CAR_DECODE;
      CAR_DECODE: begin
        if (w_jump)                 o_next = CAR_JMP_EXEC;
        else if (w_fmt1 || w_fmt2)  o_next = w_src_entry;
        else if (w_reti)            o_next = CAR_POP_SR;
        else                        o_next = CAR_FETCH;
      end
      CAR_SRC_IDX:    o_next = CAR_SRC_RD;
      CAR_SRC_RD:     o_next = w_after_src;
      CAR_SRC_RDINC:  o_next = w_after_src;
      CAR_DST_IDX:    o_next = (w_opc == C_OP_MOV) ? CAR_EXEC : CAR_DST_RD;
      CAR_DST_RD:     o_next = CAR_EXEC;
      CAR_EXEC:       o_next = w_after_exec;
      CAR_DST_WR:     o_next = CAR_FETCH;
      CAR_PUSH_DEC:   o_next = CAR_PUSH_WR;
      CAR_PUSH_WR:    o_next = (w_fmt2 && (w_op2 == C_F2_CALL)) ? CAR_CALL_PC : CAR_FETCH;
      CAR_CALL_PC:    o_next = CAR_FETCH;
      CAR_POP_SR:     o_next = CAR_POP_PC;
      CAR_POP_PC:     o_next = CAR_FETCH;
      CAR_JMP_EXEC:   o_next = CAR_FETCH;
      CAR_INT_PUSHPC: o_next = CAR_INT_PUSHSR;
      CAR_INT_PUSHSR: o_next = CAR_INT_VEC;
      CAR_INT_VEC:    o_next = CAR_FETCH;
      default:        o_next = CAR_RESET;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/car_sequencer.sv
`default_nettype none
// car_sequencer -- control address register with memory-wait hold and interrupt entry at FETCH.
// Rev 1.0

module car_sequencer
  import car_sequencer_pkg::*;
#(
  parameter int CAR_BITS = car_sequencer_pkg::C_CAR_BITS
) (
  input  logic              MCLK,
  input  logic              reset,
  car_sequencer_if.master   bus
);

  car_t r_state;
  car_t w_next;
  car_t w_dec_next;
  logic r_done;
  logic w_int_take;
  logic w_hold;

  seq_decode u_seq_decode (
    .i_ir    (bus.IR),
    .i_phase (r_state),
    .o_next  (w_dec_next)
  );

  assign w_int_take = (r_state == CAR_FETCH) && bus.IRQ && bus.GIE;
  assign w_hold     = is_mem_state(r_state) && !bus.MemReady;

  // An interrupt taken in FETCH wins over a memory stall: no fetch is performed.
  always_comb begin
    w_next = w_dec_next;
    if (w_int_take)
      w_next = CAR_INT_PUSHPC;
    else if (w_hold)
      w_next = r_state;
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_state <= CAR_RESET;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == CAR_FETCH) && (r_state != CAR_FETCH) && (r_state != CAR_RST_VEC);
    end
  end

  assign bus.CAR       = CAR_BITS'(r_state);
  assign bus.InstrDone = r_done;
  assign bus.IRload    = !reset && (r_state == CAR_FETCH) && bus.MemReady && !(bus.IRQ && bus.GIE);

endmodule

`default_nettype wire

// File: tb/tb_car_sequencer.sv
`default_nettype none
// tb_car_sequencer -- directed and randomized checks of car_sequencer against an instruction-path model.
// Rev 1.0
`timescale 1ns/1ps

module tb_car_sequencer;

  logic MCLK = 1'b0;
  logic reset;

  always #5 MCLK = ~MCLK;

  car_sequencer_if #(.CAR_BITS(6)) bus ();

  car_sequencer #(.CAR_BITS(6)) dut (
    .MCLK  (MCLK),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int q_path[$];
  int exp_q[$];
  int stalls;
  logic [15:0] r_ir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  function automatic bit is_mem(input int c);
    return c inside {1, 2, 4, 5, 6, 7, 8, 10, 12, 14, 15, 17, 18, 19};
  endfunction

  // Phases visited after FETCH for one instruction, derived from the ISA rules.
  function automatic void build_path(input logic [15:0] ir);
    bit fmt1, fmt2, cg;
    int as_m, sreg, opc, op2;
    q_path.delete();
    q_path.push_back(3);
    opc  = int'(ir[15:12]);
    op2  = int'(ir[9:7]);
    as_m = int'(ir[5:4]);
    fmt1 = (opc >= 4);
    fmt2 = (ir[15:10] == 6'b000100) && (op2 <= 5);
    if (ir[15:13] == 3'b001) begin
      q_path.push_back(16);
    end else if (fmt1 || fmt2) begin
      sreg = fmt1 ? int'(ir[11:8]) : int'(ir[3:0]);
      cg   = (sreg == 3) || (sreg == 2 && as_m >= 2);
      if (!cg) begin
        if (as_m == 1) begin q_path.push_back(4); q_path.push_back(5); end
        else if (as_m == 2) q_path.push_back(5);
        else if (as_m == 3) q_path.push_back(6);
      end
      if (fmt1 && ir[7]) begin
        q_path.push_back(7);
        if (opc != 4) q_path.push_back(8);
      end
      q_path.push_back(9);
      if (fmt2 && op2 == 4) begin
        q_path.push_back(11); q_path.push_back(12);
      end else if (fmt2 && op2 == 5) begin
        q_path.push_back(11); q_path.push_back(12); q_path.push_back(13);
      end else if (fmt1 && ir[7] && opc != 9 && opc != 11) begin
        q_path.push_back(10);
      end else if (fmt2 && op2 <= 3 && as_m != 0) begin
        q_path.push_back(10);
      end
    end else if (ir[15:7] == 9'b000100110) begin
      q_path.push_back(14); q_path.push_back(15);
    end
  endfunction

  // Starts in FETCH, runs one instruction (or interrupt entry) back to FETCH.
  task automatic run_one(input logic [15:0] ir, input bit irq_v, input bit gie_v, input bit rnd_mr);
    int cur, nxt, idx, guard;
    bit mr, take;
    take = irq_v && gie_v;
    bus.IR  = ir;
    bus.IRQ = irq_v;
    bus.GIE = gie_v;
    guard = 0;
    forever begin
      mr = (rnd_mr && guard < 6) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.MemReady = mr;
      #1;
      check("irload_fetch", 32'(bus.IRload), 32'(mr && !take));
      if (take || mr) break;
      step();
      guard++;
      check("car_fetch_hold", 32'(bus.CAR), 32'd2);
      check("done_fetch_hold", 32'(bus.InstrDone), 32'd0);
    end
    if (take) q_path = '{17, 18, 19};
    else build_path(ir);
    cur = 2; idx = 0; guard = 0;
    do begin
      if (cur != 2 && is_mem(cur) && !mr) nxt = cur;
      else begin
        nxt = (idx < q_path.size()) ? q_path[idx] : 2;
        idx++;
      end
      step();
      guard++;
      check("car", 32'(bus.CAR), 32'(nxt));
      check("instrdone", 32'(bus.InstrDone), 32'(nxt == 2 && cur != 2));
      cur = nxt;
      if (cur != 2) begin
        mr = rnd_mr ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (guard > 30) mr = 1'b1;
        bus.MemReady = mr;
        bus.IRQ = 1'($urandom_range(0, 1));
        bus.GIE = 1'($urandom_range(0, 1));
        #1;
        check("irload_busy", 32'(bus.IRload), 32'd0);
      end
    end while (cur != 2 && guard < 60);
    if (cur != 2) check("timeout_return_fetch", 32'(cur), 32'd2);
  endtask

  task automatic reset_recover();
    reset = 1'b0;
    bus.MemReady = 1'b1;
    step();
    check("rec_car1", 32'(bus.CAR), 32'd1);
    check("rec_done1", 32'(bus.InstrDone), 32'd0);
    step();
    check("rec_car2", 32'(bus.CAR), 32'd2);
    check("rec_done2", 32'(bus.InstrDone), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.IR       = 16'h0000;
    bus.MemReady = 1'b1;
    bus.IRQ      = 1'b0;
    bus.GIE      = 1'b0;

    repeat (3) begin
      step();
      check("rst_car", 32'(bus.CAR), 32'd0);
      check("rst_done", 32'(bus.InstrDone), 32'd0);
      check("rst_irload", 32'(bus.IRload), 32'd0);
    end
    reset_recover();

    run_one(16'h440A, 1'b0, 1'b0, 1'b0);
    run_one(16'h5596, 1'b0, 1'b0, 1'b0);

    // CALL @R4 with two wait cycles in PUSH_WR
    bus.IR = 16'h12A4; bus.IRQ = 1'b0; bus.GIE = 1'b0; bus.MemReady = 1'b1;
    exp_q = '{3, 5, 9, 11, 12, 12, 12, 13, 2};
    stalls = 0;
    foreach (exp_q[i]) begin
      step();
      check("call_car", 32'(bus.CAR), 32'(exp_q[i]));
      check("call_done", 32'(bus.InstrDone), 32'(i == 8));
      if (exp_q[i] == 12 && stalls < 2) begin
        bus.MemReady = 1'b0;
        stalls++;
      end else begin
        bus.MemReady = 1'b1;
      end
    end

    run_one(16'h440A, 1'b1, 1'b1, 1'b0);
    run_one(16'h440A, 1'b1, 1'b0, 1'b0);

    // interrupt taken although memory is not ready
    bus.IRQ = 1'b1; bus.GIE = 1'b1; bus.MemReady = 1'b0;
    #1;
    check("int_nomem_irload", 32'(bus.IRload), 32'd0);
    step();
    check("int_nomem_car", 32'(bus.CAR), 32'd17);
    bus.MemReady = 1'b1; bus.IRQ = 1'b0;
    exp_q = '{18, 19, 2};
    foreach (exp_q[i]) begin
      step();
      check("int_seq_car", 32'(bus.CAR), 32'(exp_q[i]));
      check("int_seq_done", 32'(bus.InstrDone), 32'(i == 2));
    end

    // reset asserted in DST_IDX
    bus.IR = 16'h5596; bus.IRQ = 1'b0; bus.GIE = 1'b0; bus.MemReady = 1'b1;
    exp_q = '{3, 4, 5, 7};
    foreach (exp_q[i]) begin
      step();
      check("pre_rst_car", 32'(bus.CAR), 32'(exp_q[i]));
    end
    reset = 1'b1;
    bus.MemReady = 1'b0;
    step();
    check("mid_rst_car", 32'(bus.CAR), 32'd0);
    check("mid_rst_done", 32'(bus.InstrDone), 32'd0);
    reset_recover();
    run_one(16'h1300, 1'b0, 1'b0, 1'b0);

    // reset in FETCH must suppress IRload
    bus.MemReady = 1'b1; bus.IRQ = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_fetch_irload", 32'(bus.IRload), 32'd0);
    step();
    check("rst_fetch_car", 32'(bus.CAR), 32'd0);
    reset_recover();

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       r_ir = 16'($urandom);
        1:       r_ir = {4'($urandom_range(4, 15)), 12'($urandom)};
        2:       r_ir = {6'b000100, 3'($urandom_range(0, 7)), 7'($urandom)};
        default: r_ir = ($urandom_range(0, 1) != 0) ? 16'h1300 : {3'b001, 13'($urandom)};
      endcase
      run_one(r_ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
